// File: rtl/uart_prot_tx_seq.sv
// uart_prot_tx_seq: Tx packet sequencer framing address, data burst, checksum and stop frames.
// Handles CTS gating, the burst limit and data-frame counting for the UART core.
module uart_prot_tx_seq #(
  parameter int DATA_W     = 8,
  parameter int ADDR_BYTES = 1,
  parameter int MAX_BURST  = 16,
  parameter int CNT_W      = 5,
  parameter int CHK_EN     = 1
) (
  input  logic              glb_clk,
  input  logic              glb_rstn,
  input  logic              cfg_txen,
  input  logic              cfg_fifo_empty,
  input  logic [DATA_W-1:0] cfg_fifo_data,
  input  logic              usr_cts,
  input  logic              core_r_en,
  output logic              prot_core_txen,
  output logic              prot_core_empty,
  output logic [1:0]        prot_cfg_txsel,
  output logic [1:0]        prot_cfg_addr_idx,
  output logic              prot_cfg_tx_r_en,
  output logic              prot_cfg_tx_rst,
  output logic [DATA_W-1:0] prot_chk,
  output logic [CNT_W-1:0]  prot_frame_cnt,
  output logic              prot_busy
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, CHK, STOP} state_t;
  localparam state_t DATA_EXIT = (CHK_EN != 0) ? CHK : STOP;
  state_t            state_q, state_d;
  logic [1:0]        addr_idx_q, addr_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] chk_q, chk_d;
  logic              inflight_q, inflight_d;
  logic              start, pop, last_addr, burst_full;
  assign start      = (state_q == IDLE) && cfg_txen && usr_cts;
  assign pop        = (state_q == DATA) && core_r_en && !cfg_fifo_empty;
  assign last_addr  = addr_idx_q == 2'(ADDR_BYTES - 1);
  assign burst_full = cnt_q == CNT_W'(MAX_BURST - 1);
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) state_q <= IDLE;
    else           state_q <= state_d;
  end
  // Leaving DATA needs either the burst limit on a pop, or an empty FIFO with no frame still owed to the core.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ADDR : IDLE;
      ADDR:    state_d = (core_r_en && last_addr) ? DATA : ADDR;
      DATA:    state_d = ((pop && burst_full) || (cfg_fifo_empty && !inflight_q)) ? DATA_EXIT : DATA;
      CHK:     state_d = core_r_en ? STOP : CHK;
      STOP:    state_d = core_r_en ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    prot_busy         = state_q != IDLE;
    prot_core_txen    = prot_busy && (usr_cts || inflight_q);
    prot_core_empty   = cfg_fifo_empty;
    prot_cfg_txsel    = (state_q == DATA) ? 2'd1 : (state_q == CHK) ? 2'd3 : (state_q == STOP) ? 2'd2 : 2'd0;
    prot_cfg_addr_idx = addr_idx_q;
    prot_cfg_tx_r_en  = pop;
    prot_cfg_tx_rst   = (state_q == STOP) && core_r_en;
    prot_chk          = chk_q;
    prot_frame_cnt    = cnt_q;
  end
  always_comb begin
    addr_idx_d = start ? 2'd0 : ((state_q == ADDR) && core_r_en && !last_addr) ? addr_idx_q + 2'd1 : addr_idx_q;
    cnt_d      = start ? '0 : pop ? cnt_q + 1'b1 : cnt_q;
    chk_d      = start ? '0 : pop ? chk_q ^ cfg_fifo_data : chk_q;
    inflight_d = core_r_en ? 1'b0 : prot_core_txen ? 1'b1 : inflight_q;
  end
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      addr_idx_q <= '0;
      cnt_q      <= '0;
      chk_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      addr_idx_q <= addr_idx_d;
      cnt_q      <= cnt_d;
      chk_q      <= chk_d;
      inflight_q <= inflight_d;
    end
  end
endmodule

// File: tb/tb_uart_prot_tx_seq.sv
// tb_uart_prot_tx_seq: randomized bench with a packet-level reference model and a simple core/FIFO model.
module tb_uart_prot_tx_seq;
  localparam int DW = 8, AB = 2, MB = 4, CW = 5;
  logic          glb_clk = 1'b0, glb_rstn = 1'b0;
  logic          cfg_txen = 1'b0, cfg_fifo_empty = 1'b1, usr_cts = 1'b1, core_r_en = 1'b0;
  logic [DW-1:0] cfg_fifo_data = '0;
  logic          prot_core_txen, prot_core_empty, prot_cfg_tx_r_en, prot_cfg_tx_rst, prot_busy;
  logic [1:0]    prot_cfg_txsel, prot_cfg_addr_idx;
  logic [DW-1:0] prot_chk;
  logic [CW-1:0] prot_frame_cnt;

  uart_prot_tx_seq #(.DATA_W(DW), .ADDR_BYTES(AB), .MAX_BURST(MB), .CNT_W(CW), .CHK_EN(1)) dut (
    .glb_clk(glb_clk), .glb_rstn(glb_rstn), .cfg_txen(cfg_txen), .cfg_fifo_empty(cfg_fifo_empty),
    .cfg_fifo_data(cfg_fifo_data), .usr_cts(usr_cts), .core_r_en(core_r_en),
    .prot_core_txen(prot_core_txen), .prot_core_empty(prot_core_empty), .prot_cfg_txsel(prot_cfg_txsel),
    .prot_cfg_addr_idx(prot_cfg_addr_idx), .prot_cfg_tx_r_en(prot_cfg_tx_r_en), .prot_cfg_tx_rst(prot_cfg_tx_rst),
    .prot_chk(prot_chk), .prot_frame_cnt(prot_frame_cnt), .prot_busy(prot_busy));

  always #5 glb_clk = ~glb_clk;

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] log_pop[$];
  int            log_sel[$];
  int            log_aidx[$];
  logic [DW-1:0] chk_seen;
  int            n_rst, data_cyc, dly = 0;
  bit            core_auto = 1'b1, force_empty = 1'b0, open = 1'b0;
  logic          s_txen, s_rd, s_rst;
  logic [1:0]    s_sel;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    log_pop.delete(); log_sel.delete(); log_aidx.delete();
    chk_seen = '1; n_rst = 0; data_cyc = 0;
  endtask

  // One clock cycle: present FIFO head, act as the core, sample mid-cycle, then pop on the edge.
  task automatic cyc();
    cfg_fifo_empty = force_empty || fifo.size() == 0;
    cfg_fifo_data  = fifo.size() == 0 ? '0 : fifo[0];
    #1;
    if (core_auto) begin
      core_r_en = 1'b0;
      if (prot_core_txen && !(prot_cfg_txsel == 2'd1 && prot_core_empty)) begin
        if (dly == 0) begin core_r_en = 1'b1; dly = $urandom_range(0, 2); end
        else dly--;
      end
    end
    #1;
    s_txen = prot_core_txen; s_rd = prot_cfg_tx_r_en; s_rst = prot_cfg_tx_rst; s_sel = prot_cfg_txsel;
    if (open) check("inflight_hold", s_txen, 1);
    else if (!usr_cts) check("cts_gate", s_txen, 0);
    if (core_r_en && s_txen) begin
      if (log_sel.size() == 0) begin
        check("cnt_clr", prot_frame_cnt, 0);
        check("chk_clr", prot_chk, 0);
      end
      log_sel.push_back(s_sel);
      if (s_sel == 2'd0) log_aidx.push_back(prot_cfg_addr_idx);
      if (s_sel == 2'd3) chk_seen = prot_chk;
    end
    if (s_rd) log_pop.push_back(cfg_fifo_data);
    if (s_rst) n_rst++;
    if (s_sel == 2'd1) data_cyc++;
    open = core_r_en ? 1'b0 : (s_txen ? 1'b1 : open);
    @(posedge glb_clk);
    if (s_rd && fifo.size() > 0) void'(fifo.pop_front());
    @(negedge glb_clk);
  endtask

  task automatic run_to_stop(string tag);
    int k = 0;
    while (n_rst == 0 && k < 300) begin cyc(); k++; end
    check(tag, k < 300, 1);
  endtask

  // Reference: AB address frames, min(fifo,MB) data frames in FIFO order, XOR checksum, stop.
  task automatic run_pkt(bit rnd);
    int n, k;
    int exp_sel[$];
    logic [DW-1:0] exp_w[$];
    logic [DW-1:0] x;
    x = '0;
    n = fifo.size() < MB ? fifo.size() : MB;
    for (int i = 0; i < n; i++) begin exp_w.push_back(fifo[i]); x ^= fifo[i]; end
    for (int i = 0; i < AB; i++) exp_sel.push_back(0);
    for (int i = 0; i < n; i++) exp_sel.push_back(1);
    exp_sel.push_back(3);
    exp_sel.push_back(2);
    clear_logs();
    cfg_txen = 1'b1;
    k = 0;
    do begin
      if (rnd) begin
        usr_cts = $urandom_range(0, 3) != 0;
        if (log_sel.size() > 0) cfg_txen = $urandom_range(0, 1);
      end
      cyc(); k++;
    end while (n_rst == 0 && k < 500);
    check("pkt_done", k < 500, 1);
    check("idle_gap", prot_busy, 0);
    cfg_txen = 1'b0; usr_cts = 1'b1;
    check("n_frames", log_sel.size(), exp_sel.size());
    for (int i = 0; i < exp_sel.size() && i < log_sel.size(); i++) check("frame_sel", log_sel[i], exp_sel[i]);
    for (int i = 0; i < AB && i < log_aidx.size(); i++) check("addr_idx", log_aidx[i], i);
    check("n_pops", log_pop.size(), n);
    for (int i = 0; i < n && i < log_pop.size(); i++) check("pop_word", log_pop[i], exp_w[i]);
    check("chk_frame", chk_seen, x);
    check("chk_hold", prot_chk, x);
    check("frame_cnt", prot_frame_cnt, n);
    check("n_rst", n_rst, 1);
    if (n == 0) check("data_cycles", data_cyc, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [DW-1:0] w3[3];
    // Reset behaviour, including input activity while held in reset.
    cfg_txen = 1'b1; core_r_en = 1'b1; cfg_fifo_empty = 1'b0;
    repeat (2) @(negedge glb_clk);
    check("rst_txen", prot_core_txen, 0);
    check("rst_busy", prot_busy, 0);
    check("rst_sel", prot_cfg_txsel, 0);
    check("rst_aidx", prot_cfg_addr_idx, 0);
    check("rst_rd", prot_cfg_tx_r_en, 0);
    check("rst_txrst", prot_cfg_tx_rst, 0);
    check("rst_chk", prot_chk, 0);
    check("rst_cnt", prot_frame_cnt, 0);
    check("rst_empty0", prot_core_empty, 0);
    cfg_fifo_empty = 1'b1; #1;
    check("rst_empty1", prot_core_empty, 1);
    cfg_txen = 1'b0; core_r_en = 1'b0;
    @(negedge glb_clk); glb_rstn = 1'b1;
    @(negedge glb_clk);
    // core_r_en while idle must be ignored.
    clear_logs();
    core_auto = 1'b0; core_r_en = 1'b1;
    cyc();
    check("idle_rd", s_rd, 0);
    check("idle_txrst", s_rst, 0);
    check("idle_busy", prot_busy, 0);
    core_r_en = 1'b0; core_auto = 1'b1;
    // Basic three-word packet.
    fifo = '{8'h11, 8'h22, 8'h0F};
    run_pkt(0);
    check("tp1_chk", chk_seen, 8'h3C);
    // Burst limit splits six words into 4 + 2.
    for (int i = 0; i < 6; i++) fifo.push_back(8'($urandom));
    run_pkt(0);
    check("burst_left", fifo.size(), 2);
    run_pkt(0);
    check("burst_drained", fifo.size(), 0);
    // Zero-data packet.
    run_pkt(0);
    // CTS dropped with a data frame in flight.
    w3 = '{8'h31, 8'h42, 8'h17};
    fifo = '{w3[0], w3[1], w3[2]};
    clear_logs(); cfg_txen = 1'b1; k = 0;
    while (log_pop.size() < 1 && k < 100) begin cyc(); k++; end
    check("cts_reach", k < 100, 1);
    cfg_txen = 1'b0; core_auto = 1'b0; core_r_en = 1'b0;
    cyc();
    check("cts_start", s_txen, 1);
    usr_cts = 1'b0;
    repeat (2) begin cyc(); check("cts_hold", s_txen, 1); end
    core_r_en = 1'b1; cyc();
    check("cts_pop", s_rd, 1);
    core_r_en = 1'b0;
    repeat (3) begin cyc(); check("cts_off", s_txen, 0); check("cts_nopop", s_rd, 0); end
    usr_cts = 1'b1; core_auto = 1'b1; dly = 0;
    run_to_stop("cts_done");
    check("cts_npop", log_pop.size(), 3);
    for (int i = 0; i < 3 && i < log_pop.size(); i++) check("cts_order", log_pop[i], w3[i]);
    check("cts_chk", chk_seen, w3[0] ^ w3[1] ^ w3[2]);
    // core_r_en coinciding with an empty FIFO in DATA.
    fifo = '{8'hA5, 8'h5A};
    clear_logs(); cfg_txen = 1'b1; k = 0;
    while (log_pop.size() < 1 && k < 100) begin cyc(); k++; end
    check("co_reach", k < 100, 1);
    cfg_txen = 1'b0; core_auto = 1'b0; core_r_en = 1'b0;
    cyc();
    force_empty = 1'b1; core_r_en = 1'b1;
    cyc();
    check("co_nopop", s_rd, 0);
    check("co_sel", s_sel, 1);
    core_r_en = 1'b0;
    check("co_chk", prot_chk, 8'hA5);
    check("co_cnt", prot_frame_cnt, 1);
    check("co_still_data", prot_cfg_txsel, 1);
    cyc();
    check("co_to_chk", prot_cfg_txsel, 3);
    force_empty = 1'b0; core_auto = 1'b1;
    run_to_stop("co_done");
    check("co_left", fifo.size(), 1);
    fifo.delete();
    // Reset in the middle of DATA after two pops.
    fifo = '{8'h01, 8'h02, 8'h04, 8'h08};
    clear_logs(); cfg_txen = 1'b1; k = 0;
    while (log_pop.size() < 2 && k < 100) begin cyc(); k++; end
    check("mr_reach", k < 100, 1);
    cfg_txen = 1'b0; core_r_en = 1'b0;
    glb_rstn = 1'b0; #1;
    check("mr_busy", prot_busy, 0);
    check("mr_txen", prot_core_txen, 0);
    check("mr_sel", prot_cfg_txsel, 0);
    check("mr_cnt", prot_frame_cnt, 0);
    check("mr_chk", prot_chk, 0);
    check("mr_rd", prot_cfg_tx_r_en, 0);
    check("mr_empty", prot_core_empty, cfg_fifo_empty);
    open = 1'b0; dly = 0;
    @(negedge glb_clk); glb_rstn = 1'b1;
    @(negedge glb_clk);
    check("mr_left", fifo.size(), 2);
    run_pkt(0);
    // Randomized packets with random CTS, core latency and txen deassertion.
    repeat (30) begin
      fifo.delete();
      k = $urandom_range(0, 7);
      for (int i = 0; i < k; i++) fifo.push_back(8'($urandom));
      run_pkt(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_prot_tx_seq.md
Name: uart_prot_tx_seq

Overview:
Parametrised Tx protocol sequencer for the UART protocol layer. It frames each packet as N address frames, up to MAX_BURST data frames popped from the Tx FIFO, an optional XOR checksum frame, and a stop frame. It drives the frame-select mux and FIFO controls in the config layer and the enable into the UART core. It also adds CTS flow control, a burst limit, and frame counting.

Parameters:
DATA_W, 8, frame data width
ADDR_BYTES, 1, address frames per packet (1..4)
MAX_BURST, 16, max data frames per packet before a forced checksum/stop (>=1)
CNT_W, 5, data-frame counter width, >= clog2(MAX_BURST+1)
CHK_EN, 1, 1 = append checksum frame before stop; 0 = skip it

Ports:
glb_clk  in  1  clock, rising edge
glb_rstn  in  1  asynchronous active-low reset
cfg_txen  in  1  packet start request (level)
cfg_fifo_empty  in  1  Tx FIFO empty
cfg_fifo_data  in  DATA_W  Tx FIFO head word (first-word-fall-through)
usr_cts  in  1  clear-to-send, active high
core_r_en  in  1  1-cycle pulse: core has accepted the current frame
prot_core_txen  out  1  frame request to core
prot_core_empty  out  1  pass-through of cfg_fifo_empty
prot_cfg_txsel  out  2  0=address, 1=data, 2=stop, 3=checksum
prot_cfg_addr_idx  out  2  index of the address byte being sent
prot_cfg_tx_r_en  out  1  FIFO pop pulse
prot_cfg_tx_rst  out  1  end-of-packet reset pulse to config layer
prot_chk  out  DATA_W  running XOR of sent data words
prot_frame_cnt  out  CNT_W  data frames sent in current packet
prot_busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ADDR, DATA, CHK, STOP. State, addr_idx, cnt, chk and inflight are registered. All other outputs are combinational from state and inputs.
- Reset (async, glb_rstn=0): state=IDLE; addr_idx, cnt, chk and inflight all 0. Every output is 0 except prot_core_empty, which follows cfg_fifo_empty. No pulses are generated during reset.
- inflight: set on any cycle with prot_core_txen=1 and core_r_en=0; cleared on core_r_en.
- prot_core_txen = (state != IDLE) & (usr_cts | inflight). CTS only gates the start of a frame. A frame already in flight is never aborted.
- IDLE: if cfg_txen=1 and usr_cts=1, go to ADDR and clear addr_idx, cnt and chk. prot_core_txen first asserts the cycle after cfg_txen is sampled. txsel=0.
- ADDR: txsel=0, addr_idx driven out. On core_r_en: if addr_idx==ADDR_BYTES-1, go to DATA; otherwise increment addr_idx.
- DATA: txsel=1. prot_cfg_tx_r_en = core_r_en & !cfg_fifo_empty. On a pop, chk ^= cfg_fifo_data and cnt++.
  - If the pop makes cnt==MAX_BURST, exit DATA.
  - If cfg_fifo_empty=1 and inflight=0, exit DATA.
  - Exit target is CHK if CHK_EN, otherwise STOP.
  - If core_r_en coincides with empty, there is no pop (gated), and DATA exits the following cycle.
- Zero-data packet: entering DATA with the FIFO empty exits directly; cnt=0, chk=0.
- CHK: txsel=3; prot_chk is the frame payload. On core_r_en, go to STOP.
- STOP: txsel=2. prot_cfg_tx_rst = core_r_en. On core_r_en, go to IDLE. At least one IDLE cycle always separates packets, even if cfg_txen stays high.
- cfg_txen deasserting mid-packet is ignored; the packet completes. cnt and chk hold their values in IDLE until the next start.
- core_r_en in IDLE is ignored: no pulses, no state change.
- Reset asserted mid-packet returns to IDLE immediately. Remaining FIFO data is not popped.

Test Plan:
- ADDR_BYTES=2, CHK_EN=1, FIFO holds 0x11,0x22,0x0F; cfg_txen pulse with usr_cts=1 -> txsel sequence 0,0,1,1,1,3,2; exactly 3 tx_r_en pulses; prot_chk=0x3C at CHK; one tx_rst pulse at the STOP accept; then IDLE.
- MAX_BURST=4, FIFO holds 6 words -> after the 4th pop, go to CHK then STOP; prot_frame_cnt=4; 2 words remain in the FIFO; a second cfg_txen sends the remaining 2.
- Start with an empty FIFO, CHK_EN=1 -> ADDR, then DATA for 1 cycle, then CHK with chk=0x00, then STOP; no tx_r_en pulse.
- usr_cts dropped in DATA while a frame is inflight -> txen stays 1 until core_r_en, then 0 until usr_cts=1; no pops while cts=0; data order preserved.
- core_r_en and cfg_fifo_empty both 1 in the same DATA cycle -> no tx_r_en and chk unchanged; CHK state follows on the next cycle.
- glb_rstn pulsed low during DATA after 2 pops -> state=IDLE and all outputs at reset values immediately; after release, cfg_txen restarts cleanly with cnt=0.
